// File: rtl/apb_pkg.sv
// APB master bridge shared definitions.
// Default geometry and the FSM state encoding.
package apb_pkg;

  localparam int ADDR_W_DEF  = 3;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_state_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// APB requester/completer signal bundle.
// The master modport drives the bus, the slave modport answers it.
interface apb_interface
  import apb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  modport master (
    output paddr,
    output psel,
    output penable,
    output pwrite,
    output pwdata,
    input  pready,
    input  prdata
  );

  modport slave (
    input  paddr,
    input  psel,
    input  penable,
    input  pwrite,
    input  pwdata,
    output pready,
    output prdata
  );

endinterface

// File: rtl/apb_master_bridge.sv
// Command/response to APB master bridge.
// One transfer in flight; ACCESS is bounded by a wait-cycle timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  apb_interface.master      apb
);

  apb_state_t        state;
  apb_state_t        state_nxt;
  logic [7:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              timeout_hit;
  logic              acc_done;

  assign accept      = cmd_valid && cmd_ready;
  assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));
  assign acc_done    = (state == ST_ACCESS) &&
                       (apb.pready || timeout_hit);

  assign apb.paddr  = addr_q;
  assign apb.pwrite = write_q;
  assign apb.pwdata = wdata_q;

  // State register
  always_ff @(posedge pclk) begin
    if (preset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; pready wins over an expiring timeout
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (accept)    state_nxt = ST_SETUP;
      ST_SETUP:                 state_nxt = ST_ACCESS;
      ST_ACCESS: if (acc_done)  state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and bus-phase outputs decoded from state
  always_comb begin
    cmd_ready   = 1'b0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    rsp_valid   = 1'b0;
    unique case (1'b1)
      state == ST_IDLE:   cmd_ready = !preset;
      state == ST_SETUP:  apb.psel = 1'b1;
      state == ST_ACCESS: begin
        apb.psel    = 1'b1;
        apb.penable = 1'b1;
      end
      state == ST_RESP:   rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Wait counter: cleared on SETUP entry, counts stalled ACCESS cycles
  always_ff @(posedge pclk) begin
    if (preset)
      wait_cnt <= '0;
    else if (accept)
      wait_cnt <= '0;
    else if (state == ST_ACCESS && !apb.pready)
      wait_cnt <= wait_cnt + 8'd1;
  end

  // Command latch; bus fields hold their values until the next accept
  always_ff @(posedge pclk) begin
    if (preset) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= cmd_addr;
      write_q <= cmd_write;
      wdata_q <= cmd_wdata;
    end
  end

  // Response capture at the end of ACCESS; held through RESP
  always_ff @(posedge pclk) begin
    if (preset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (acc_done) begin
      rsp_err   <= !apb.pready;
      rsp_rdata <= (apb.pready && !write_q) ? apb.prdata : '0;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge.
// Completer behaviour is driven inline; expectations are hand-computed.
module tb_apb_master_bridge;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          preset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  int n_cmp  = 0;
  int n_fail = 0;

  apb_interface #(.ADDR_W(AW), .DATA_W(DW)) apb ();

  apb_master_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (apb)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command; pready is held low for `waits` ACCESS cycles.
  // Holds rsp_ready low for `bp` cycles in RESP while offering a new command.
  task automatic xfer(input logic          wr,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] wd,
                      input int            waits,
                      input logic [DW-1:0] rd,
                      input int            exp_n,
                      input logic          exp_err,
                      input logic [DW-1:0] exp_rd,
                      input int            bp);
    int n;
    @(negedge pclk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    apb.pready = 1'b1;
    apb.prdata = 16'hDEAD;
    @(negedge pclk);
    cmd_valid = 1'b0;
    cmd_addr  = ~a;
    cmd_wdata = ~wd;
    apb.pready = 1'b0;
    chk("setup_psel", 32'(apb.psel), 32'd1);
    chk("setup_penable", 32'(apb.penable), 32'd0);
    chk("setup_paddr", 32'(apb.paddr), 32'(a));
    chk("setup_pwrite", 32'(apb.pwrite), 32'(wr));
    chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    n = 0;
    @(negedge pclk);
    while (apb.psel && apb.penable && n < 40) begin
      n++;
      if (n == 1 || n == exp_n) begin
        chk("acc_paddr", 32'(apb.paddr), 32'(a));
        chk("acc_pwdata", 32'(apb.pwdata), 32'(wd));
        chk("acc_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      apb.pready = (n > waits);
      apb.prdata = (n > waits) ? rd : 16'hDEAD;
      @(negedge pclk);
    end
    apb.pready = 1'b1;
    apb.prdata = 16'h5A5A;
    chk("acc_cycles", 32'(n), 32'(exp_n));
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_err", 32'(rsp_err), 32'(exp_err));
    chk("resp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    chk("resp_psel", 32'(apb.psel), 32'd0);
    chk("resp_penable", 32'(apb.penable), 32'd0);
    rsp_ready = 1'b0;
    cmd_valid = (bp > 0);
    for (int i = 0; i < bp; i++) begin
      @(negedge pclk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", 32'(rsp_rdata), 32'(exp_rd));
      chk("bp_err", 32'(rsp_err), 32'(exp_err));
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_psel", 32'(apb.psel), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    apb.pready = 1'b0;
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("done_psel", 32'(apb.psel), 32'd0);
  endtask

  initial begin
    preset     = 1'b1;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    rsp_ready  = 1'b0;
    apb.pready = 1'b0;
    apb.prdata = '0;
    repeat (3) @(negedge pclk);
    chk("rst_psel", 32'(apb.psel), 32'd0);
    chk("rst_penable", 32'(apb.penable), 32'd0);
    chk("rst_pwrite", 32'(apb.pwrite), 32'd0);
    chk("rst_paddr", 32'(apb.paddr), 32'd0);
    chk("rst_pwdata", 32'(apb.pwdata), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    preset = 1'b0;
    @(negedge pclk);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // write, zero wait
    xfer(1'b1, 3'd3, 16'hA5A5, 0, 16'h0000, 1, 1'b0, 16'h0000, 0);
    // read, two waits
    xfer(1'b0, 3'd5, 16'h0000, 2, 16'h1234, 3, 1'b0, 16'h1234, 0);
    // timeout
    xfer(1'b0, 3'd6, 16'h0000, 100, 16'h0000, 16, 1'b1, 16'h0000, 0);
    // pready on the last allowed cycle
    xfer(1'b0, 3'd2, 16'h0000, 15, 16'hBEEF, 16, 1'b0, 16'hBEEF, 0);
    // write with response backpressure
    xfer(1'b1, 3'd7, 16'h0F0F, 1, 16'hFFFF, 2, 1'b0, 16'h0000, 5);
    // read with backpressure
    xfer(1'b0, 3'd1, 16'h0000, 0, 16'hC3C3, 1, 1'b0, 16'hC3C3, 5);

    // reset in the middle of a waited ACCESS
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 3'd4;
    @(negedge pclk);
    cmd_valid = 1'b0;
    apb.pready = 1'b0;
    repeat (3) @(negedge pclk);
    chk("mid_in_access", 32'(apb.penable), 32'd1);
    preset = 1'b1;
    apb.pready = 1'b1;
    apb.prdata = 16'h7777;
    @(negedge pclk);
    chk("mid_psel", 32'(apb.psel), 32'd0);
    chk("mid_penable", 32'(apb.penable), 32'd0);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_paddr", 32'(apb.paddr), 32'd0);
    chk("mid_rsp_rdata", 32'(rsp_rdata), 32'd0);
    preset = 1'b0;
    @(negedge pclk);
    chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge pclk);
    chk("mid_no_rsp2", 32'(rsp_valid), 32'd0);
    chk("mid_no_psel", 32'(apb.psel), 32'd0);

    // recovery transfer
    xfer(1'b0, 3'd4, 16'h0000, 1, 16'h4242, 2, 1'b0, 16'h4242, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
